branch_compare_seq: RTL and testbench

Multi-cycle branch resolution controller for the RV32I core. It sequences one shared SLICE_W-bit subtract/zero-detect slice across the 32-bit operands, LSB first. It accumulates carry and zero status to derive EQ, LT and LTU, then evaluates the funct3 branch condition. It sits between decode/issue and the PC-select logic, with a valid/ready request side and a valid/ready result side.

---
 rtl/branch_compare_seq.sv | 194 +++++++++++++++++++
 tb/tb_branch_compare_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_compare_seq.sv
// -----------------------------------------------------------------------------
// branch_compare_seq
//   Multi-cycle branch resolution for the RV32I core. One SLICE_W-bit
//   subtract/zero-detect slice is walked across the 32-bit operands, LSB
//   first. The walk accumulates the borrow chain and a running zero flag.
//   When the walk ends, EQ/LT/LTU are formed and the funct3 condition is
//   evaluated.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   request valid              in_ready   block is idle and can accept
//   rs1, rs2   32-bit operands            funct3     branch type
//   flush      synchronous abort; drops any in-flight or presented request
//   out_valid  result valid               out_ready  consumer accepts result
//   taken      branch condition           eq/lt/ltu  compare flags
//   illegal    funct3 was 010 or 011      busy       not idle
// -----------------------------------------------------------------------------
module branch_compare_seq #(
  parameter int SLICE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  funct3,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        taken,
  output logic        eq,
  output logic        lt,
  output logic        ltu,
  output logic        illegal,
  output logic        busy
);

  localparam int NSLICES = 32 / SLICE_W;
  localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_idx;
  logic              r_carry;
  logic              r_zero;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [2:0]        r_f3;
  logic              r_a_msb;
  logic              r_sign_diff;
  logic              r_out_valid;
  logic              r_taken;
  logic              r_eq;
  logic              r_lt;
  logic              r_ltu;
  logic              r_illegal;

  logic [SLICE_W:0]  w_sum;
  logic              w_carry_nxt;
  logic              w_zero_nxt;
  logic              w_ltu;
  logic              w_lt;
  logic              w_f3_illegal;

  function automatic logic branch_taken(input logic [2:0] f3, input logic e,
                                        input logic s_lt, input logic u_lt);
    logic t;
    t = 1'b0;
    case (f3)
      3'b000:  t = e;
      3'b001:  t = ~e;
      3'b100:  t = s_lt;
      3'b101:  t = ~s_lt;
      3'b110:  t = u_lt;
      3'b111:  t = ~u_lt;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // The operand registers are shifted right each RUN cycle, so the active
  // slice always sits in the low SLICE_W bits. A + ~B + 1 chained across
  // slices gives A - B; a final carry of 0 means a borrow, i.e. A < B unsigned.
  assign w_sum        = {1'b0, r_a[SLICE_W-1:0]} + {1'b0, ~r_b[SLICE_W-1:0]}
                      + {{SLICE_W{1'b0}}, r_carry};
  assign w_carry_nxt  = w_sum[SLICE_W];
  assign w_zero_nxt   = r_zero & (w_sum[SLICE_W-1:0] == '0);
  assign w_ltu        = ~w_carry_nxt;
  // Differing signs decide signed order directly: the negative one is smaller.
  assign w_lt         = r_sign_diff ? r_a_msb : w_ltu;
  assign w_f3_illegal = (funct3[2:1] == 2'b01);

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign taken     = r_taken;
  assign eq        = r_eq;
  assign lt        = r_lt;
  assign ltu       = r_ltu;
  assign illegal   = r_illegal;

  // Control and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b1;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
      r_taken     <= 1'b0;
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
      r_ltu       <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b1;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
      r_taken     <= 1'b0;
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
      r_ltu       <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_idx   <= '0;
            r_carry <= 1'b1;
            r_zero  <= 1'b1;
            if (w_f3_illegal) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_illegal   <= 1'b1;
              r_taken     <= 1'b0;
              r_eq        <= 1'b0;
              r_lt        <= 1'b0;
              r_ltu       <= 1'b0;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_carry <= w_carry_nxt;
          r_zero  <= w_zero_nxt;
          r_idx   <= r_idx + CNT_W'(1);
          if (r_idx == LAST) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_eq        <= w_zero_nxt;
            r_ltu       <= w_ltu;
            r_lt        <= w_lt;
            r_illegal   <= 1'b0;
            r_taken     <= branch_taken(r_f3, w_zero_nxt, w_lt, w_ltu);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_taken     <= 1'b0;
            r_eq        <= 1'b0;
            r_lt        <= 1'b0;
            r_ltu       <= 1'b0;
            r_illegal   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand capture and slice shifting (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && in_valid) begin
      r_a         <= rs1;
      r_b         <= rs2;
      r_f3        <= funct3;
      r_a_msb     <= rs1[31];
      r_sign_diff <= rs1[31] ^ rs2[31];
    end else if (r_state == S_RUN) begin
      r_a <= r_a >> SLICE_W;
      r_b <= r_b >> SLICE_W;
    end
  end

endmodule

// File: tb/tb_branch_compare_seq.sv
// -----------------------------------------------------------------------------
// tb_branch_compare_seq
//   Four instances at SLICE_W = 8, 1, 4, 32. Instance 0 takes the directed
//   scenarios; instances 1..3 take randomized operand sweeps. A reference
//   model computes results from plain integer comparisons, and one compare
//   process checks every instance on every falling edge.
// -----------------------------------------------------------------------------
module tb_branch_compare_seq;

  localparam int ND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [ND-1:0]   in_valid_v;
  logic [ND-1:0]   flush_v;
  logic [ND-1:0]   out_ready_v;
  logic [31:0]     rs1_v [ND];
  logic [31:0]     rs2_v [ND];
  logic [2:0]      f3_v  [ND];
  wire  [ND-1:0]   in_ready_v;
  wire  [ND-1:0]   out_valid_v;
  wire  [ND-1:0]   taken_v;
  wire  [ND-1:0]   eq_v;
  wire  [ND-1:0]   lt_v;
  wire  [ND-1:0]   ltu_v;
  wire  [ND-1:0]   illegal_v;
  wire  [ND-1:0]   busy_v;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int SW = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
    branch_compare_seq #(.SLICE_W(SW)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .rs1       (rs1_v[g]),
      .rs2       (rs2_v[g]),
      .funct3    (f3_v[g]),
      .flush     (flush_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .taken     (taken_v[g]),
      .eq        (eq_v[g]),
      .lt        (lt_v[g]),
      .ltu       (ltu_v[g]),
      .illegal   (illegal_v[g]),
      .busy      (busy_v[g])
    );
  end

  typedef struct packed {
    logic taken;
    logic eq;
    logic lt;
    logic ltu;
    logic illegal;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   nsl     [ND] = '{4, 32, 8, 1};
  res_t exp_r   [ND];
  bit   pend    [ND];
  bit   seen    [ND];
  int   acc_cyc [ND];
  int   exp_lat [ND];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f3);
    res_t r;
    r = '0;
    if (f3 == 3'b010 || f3 == 3'b011) begin
      r.illegal = 1'b1;
      return r;
    end
    r.eq  = (a == b);
    r.lt  = ($signed(a) < $signed(b));
    r.ltu = (a < b);
    case (f3)
      3'b000:  r.taken = r.eq;
      3'b001:  r.taken = !r.eq;
      3'b100:  r.taken = r.lt;
      3'b101:  r.taken = !r.lt;
      3'b110:  r.taken = r.ltu;
      3'b111:  r.taken = !r.ltu;
      default: r.taken = 1'b0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Compare process: every instance, every falling edge while out of reset.
  always @(negedge clk) begin
    if (reset) begin
      for (int k = 0; k < ND; k++) begin
        if (!pend[k]) begin
          chk($sformatf("idle_valid%0d", k), 32'(out_valid_v[k]), 0);
        end else if (out_valid_v[k]) begin
          chk($sformatf("taken%0d", k),    32'(taken_v[k]),    32'(exp_r[k].taken));
          chk($sformatf("eq%0d", k),       32'(eq_v[k]),       32'(exp_r[k].eq));
          chk($sformatf("lt%0d", k),       32'(lt_v[k]),       32'(exp_r[k].lt));
          chk($sformatf("ltu%0d", k),      32'(ltu_v[k]),      32'(exp_r[k].ltu));
          chk($sformatf("illegal%0d", k),  32'(illegal_v[k]),  32'(exp_r[k].illegal));
          chk($sformatf("in_ready_done%0d", k), 32'(in_ready_v[k]), 0);
          chk($sformatf("busy_done%0d", k),     32'(busy_v[k]),     1);
          if (!seen[k]) begin
            chk($sformatf("latency%0d", k), 32'(cyc - acc_cyc[k]), 32'(exp_lat[k]));
            seen[k] = 1'b1;
          end
        end
      end
    end
  end

  // All tasks are entered 1 time unit after a rising edge.
  task automatic launch(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3);
    int n;
    n = 0;
    while (!in_ready_v[k] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready_v[k]) chk("in_ready_wait", 0, 1);
    rs1_v[k]      = a;
    rs2_v[k]      = b;
    f3_v[k]       = f3;
    in_valid_v[k] = 1'b1;
    exp_r[k]      = model(a, b, f3);
    exp_lat[k]    = exp_r[k].illegal ? 0 : nsl[k];
    acc_cyc[k]    = cyc + 1;
    seen[k]       = 1'b0;
    pend[k]       = 1'b1;
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    while (!out_valid_v[k] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid_v[k]) chk($sformatf("valid_timeout%0d", k), 0, 1);
  endtask

  task automatic complete(input int k);
    out_ready_v[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[k] = 1'b0;
    pend[k]        = 1'b0;
    chk($sformatf("post_hs_valid%0d", k), 32'(out_valid_v[k]), 0);
    chk($sformatf("post_hs_ready%0d", k), 32'(in_ready_v[k]), 1);
  endtask

  task automatic run(input int k, input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] f3, output res_t got);
    launch(k, a, b, f3);
    wait_valid(k);
    got.taken   = taken_v[k];
    got.eq      = eq_v[k];
    got.lt      = lt_v[k];
    got.ltu     = ltu_v[k];
    got.illegal = illegal_v[k];
    complete(k);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    res_t        r;
    logic [31:0] a, b;
    logic [2:0]  f3s [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

    reset       = 1'b0;
    in_valid_v  = '0;
    flush_v     = '0;
    out_ready_v = '0;
    for (int k = 0; k < ND; k++) begin
      rs1_v[k] = '0; rs2_v[k] = '0; f3_v[k] = '0;
      pend[k] = 1'b0; seen[k] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready_v[0]),  1);
    chk("rst_out_valid", 32'(out_valid_v[0]), 0);
    chk("rst_busy",      32'(busy_v[0]),      0);
    chk("rst_flags",     32'({taken_v[0], eq_v[0], lt_v[0], ltu_v[0], illegal_v[0]}), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Pin the reference model with hand-derived values
    r = model(32'hFFFF_FFFF, 32'h1, 3'b100);
    chk("model_blt", 32'({r.taken, r.lt, r.ltu}), 32'b110);
    r = model(32'hFFFF_FFFF, 32'h1, 3'b110);
    chk("model_bltu", 32'(r.taken), 0);
    r = model(32'h1234_5678, 32'h1234_5678, 3'b000);
    chk("model_beq", 32'({r.taken, r.eq, r.lt, r.ltu}), 32'b1100);
    r = model(32'h0, 32'h0, 3'b011);
    chk("model_illegal", 32'({r.illegal, r.taken}), 32'b10);

    // BEQ equal operands, 4-cycle latency at SLICE_W=8
    launch(0, 32'h1234_5678, 32'h1234_5678, 3'b000);
    wait_valid(0);
    chk("beq_latency", 32'(cyc - acc_cyc[0]), 4);
    chk("beq_flags", 32'({taken_v[0], eq_v[0], lt_v[0], ltu_v[0]}), 32'b1100);
    complete(0);

    // -1 vs 1: signed less, unsigned greater
    run(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, r);
    chk("blt_flags", 32'({r.taken, r.lt, r.ltu}), 32'b110);
    run(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, r);
    chk("bltu_taken", 32'(r.taken), 0);
    run(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, r);
    chk("bgeu_taken", 32'(r.taken), 1);

    // Zero low slices, nonzero upper slice
    run(0, 32'h0001_0000, 32'h0000_0000, 3'b001, r);
    chk("bne_flags", 32'({r.eq, r.taken}), 32'b01);

    // Illegal funct3, then a normal request
    launch(0, 32'h5, 32'h5, 3'b011);
    chk("illegal_next_cycle", 32'({out_valid_v[0], illegal_v[0], taken_v[0]}), 32'b110);
    complete(0);
    run(0, 32'd5, 32'd7, 3'b101, r);
    chk("bge_after_illegal", 32'({r.taken, r.lt, r.illegal}), 32'b010);

    // Backpressure: result held for 5 cycles
    launch(0, 32'd3, 32'd9, 3'b110);
    wait_valid(0);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(out_valid_v[0]), 1);
      chk("bp_in_ready", 32'(in_ready_v[0]), 0);
    end
    chk("bp_taken", 32'(taken_v[0]), 1);
    complete(0);

    // Flush while processing slice index 2
    launch(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush_v[0] = 1'b1;
    @(posedge clk); #1;
    flush_v[0] = 1'b0;
    pend[0]    = 1'b0;
    chk("flush_run_busy", 32'(busy_v[0]), 0);
    chk("flush_run_ready", 32'(in_ready_v[0]), 1);
    repeat (8) @(posedge clk);
    #1;

    // Request presented together with flush is dropped
    rs1_v[0] = 32'h1; rs2_v[0] = 32'h2; f3_v[0] = 3'b100;
    in_valid_v[0] = 1'b1;
    flush_v[0]    = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    flush_v[0]    = 1'b0;
    chk("flush_drop_busy", 32'(busy_v[0]), 0);

    // Flush in DONE clears the result and beats the handshake
    launch(0, 32'd1, 32'd1, 3'b000);
    wait_valid(0);
    flush_v[0]     = 1'b1;
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    flush_v[0]     = 1'b0;
    out_ready_v[0] = 1'b0;
    pend[0]        = 1'b0;
    chk("flush_done_clear", 32'({out_valid_v[0], taken_v[0], eq_v[0]}), 0);

    // Reset asserted mid-RUN, then a normal request
    launch(0, 32'h8000_0000, 32'h7FFF_FFFF, 3'b100);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    pend[0] = 1'b0;
    chk("rst_mid_busy",  32'(busy_v[0]),     0);
    chk("rst_mid_ready", 32'(in_ready_v[0]), 1);
    chk("rst_mid_valid", 32'(out_valid_v[0]), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run(0, 32'h8000_0000, 32'h7FFF_FFFF, 3'b100, r);
    chk("after_rst_blt", 32'({r.taken, r.lt, r.ltu}), 32'b110);

    // Randomized sweep on SLICE_W = 1, 4, 32
    for (int k = 1; k < ND; k++) begin
      for (int f = 0; f < 6; f++) begin
        for (int i = 0; i < 40; i++) begin
          a = $urandom;
          case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = $urandom;
            2:       b = a ^ (32'h1 << $urandom_range(0, 31));
            default: b = {~a[31], a[30:0]};
          endcase
          run(k, a, b, f3s[f], r);
        end
      end
      run(k, 32'h0, 32'h0, 3'b010, r);
      chk($sformatf("sweep_illegal%0d", k), 32'({r.illegal, r.taken}), 32'b10);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
